// File: rtl/pc_unit.sv
// pc_unit: program counter for the HACK CPU datapath with a hardware return-address stack.
//
// The PC is a registered counter that supports clear, load, increment by STEP,
// call (push return address, jump) and return (pop into PC). out_o drives the
// instruction ROM address directly.
//
// Ports:
//   clk_i        - clock, all state updates on the rising edge
//   rst_n        - asynchronous active-low reset
//   in_i         - jump / call target address
//   clr_i        - synchronous clear of PC to RESET_VAL (highest priority)
//   call_i       - push PC + STEP, PC <= in_i
//   ret_i        - PC <= top of stack, pop
//   load_i       - PC <= in_i
//   inc_i        - PC <= PC + STEP (lowest priority)
//   out_o        - current PC (registered)
//   depth_cnt_o  - number of valid return-stack entries
//   full_o       - stack holds DEPTH entries
//   empty_o      - stack holds no entries
//   err_ovf_o    - one-cycle pulse: call rejected because the stack was full
//   err_unf_o    - one-cycle pulse: ret rejected because the stack was empty
//   wrap_o       - one-cycle pulse: inc / call return address wrapped past 2^WIDTH-1
//
// Op priority: clr > call > ret > load > inc > hold. Losing strobes are dropped silently.

module pc_unit #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      STEP      = 1,
  parameter int unsigned      DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_i,
  input  logic                     clr_i,
  input  logic                     load_i,
  input  logic                     inc_i,
  input  logic                     call_i,
  input  logic                     ret_i,
  output logic [WIDTH-1:0]         out_o,
  output logic [$clog2(DEPTH):0]   depth_cnt_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     err_ovf_o,
  output logic                     err_unf_o,
  output logic                     wrap_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // STEP widened by one bit so the sum exposes the carry used for wrap.
  localparam logic [WIDTH:0]  StepExt = (WIDTH + 1)'(STEP);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wrap_q, wrap_d;

  // Stack contents need no reset: entries are only read below depth_cnt.
  logic [WIDTH-1:0] stack_q [DEPTH];

  logic [WIDTH:0]   pc_sum;
  logic [WIDTH-1:0] pc_step;
  logic             pc_carry;
  logic             full, empty;
  logic             push_en;
  logic [PtrW-1:0]  push_idx;
  logic [PtrW-1:0]  pop_idx;

  assign pc_sum   = {1'b0, pc_q} + StepExt;
  assign pc_step  = pc_sum[WIDTH-1:0];
  assign pc_carry = pc_sum[WIDTH];

  assign full  = (cnt_q == DepthCnt);
  assign empty = (cnt_q == '0);

  // A push only happens when not full, so cnt_q < DEPTH and the low bits index
  // the next free slot. A pop only happens when not empty, so cnt_q - 1 >= 0.
  assign push_idx = PtrW'(cnt_q);
  assign pop_idx  = PtrW'(cnt_q - 1'b1);

  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    wrap_d  = 1'b0;
    push_en = 1'b0;
    if (clr_i) begin
      pc_d = RESET_VAL;
    end else if (call_i) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        push_en = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        pc_d    = in_i;
        wrap_d  = pc_carry;
      end
    end else if (ret_i) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        pc_d  = stack_q[pop_idx];
        cnt_d = cnt_q - 1'b1;
      end
    end else if (load_i) begin
      pc_d = in_i;
    end else if (inc_i) begin
      pc_d   = pc_step;
      wrap_d = pc_carry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_VAL;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      wrap_q <= wrap_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      stack_q[push_idx] <= pc_step;
    end
  end

  assign out_o       = pc_q;
  assign depth_cnt_o = cnt_q;
  assign full_o      = full;
  assign empty_o     = empty;
  assign err_ovf_o   = ovf_q;
  assign err_unf_o   = unf_q;
  assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit.
// Two instances share stimulus: dut (STEP=1) and dut2 (STEP=2, checked only
// where the step size matters).

module tb_pc_unit;

  logic        clk_i;
  logic        rst_n;
  logic [15:0] in_i;
  logic        clr_i, load_i, inc_i, call_i, ret_i;

  logic [15:0] out_o;
  logic [3:0]  depth_cnt_o;
  logic        full_o, empty_o, err_ovf_o, err_unf_o, wrap_o;

  logic [15:0] out2;
  logic [3:0]  depth2;
  logic        full2, empty2, ovf2, unf2, wrap2;

  int vec_cnt = 0;
  int err_cnt = 0;

  pc_unit #(.WIDTH(16), .STEP(1), .DEPTH(8), .RESET_VAL(16'h0000)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .in_i(in_i), .clr_i(clr_i), .load_i(load_i),
    .inc_i(inc_i), .call_i(call_i), .ret_i(ret_i), .out_o(out_o),
    .depth_cnt_o(depth_cnt_o), .full_o(full_o), .empty_o(empty_o),
    .err_ovf_o(err_ovf_o), .err_unf_o(err_unf_o), .wrap_o(wrap_o)
  );

  pc_unit #(.WIDTH(16), .STEP(2), .DEPTH(8), .RESET_VAL(16'h0000)) dut2 (
    .clk_i(clk_i), .rst_n(rst_n), .in_i(in_i), .clr_i(clr_i), .load_i(load_i),
    .inc_i(inc_i), .call_i(call_i), .ret_i(ret_i), .out_o(out2),
    .depth_cnt_o(depth2), .full_o(full2), .empty_o(empty2),
    .err_ovf_o(ovf2), .err_unf_o(unf2), .wrap_o(wrap2)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    in_i = '0; clr_i = 0; load_i = 0; inc_i = 0; call_i = 0; ret_i = 0;
  endtask

  task automatic do_load(input logic [15:0] v);
    idle(); load_i = 1; in_i = v; tick(); idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #12;
    vec_cnt++;
    if (out_o !== 16'h0000) begin err_cnt++; $display("FAIL reset_out got %h want 0000", out_o); end
    vec_cnt++;
    if (depth_cnt_o !== 4'd0) begin
      err_cnt++; $display("FAIL reset_depth got %0d want 0", depth_cnt_o);
    end
    vec_cnt++;
    if ({empty_o, full_o} !== 2'b10) begin
      err_cnt++; $display("FAIL reset_empty_full got %b want 10", {empty_o, full_o});
    end
    vec_cnt++;
    if ({err_ovf_o, err_unf_o, wrap_o} !== 3'b000) begin
      err_cnt++; $display("FAIL reset_flags got %b want 000", {err_ovf_o, err_unf_o, wrap_o});
    end
    @(negedge clk_i);
    rst_n = 1;
    tick();
  endtask

  task automatic test_inc();
    inc_i = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      vec_cnt++;
      if (out_o !== 16'(i)) begin err_cnt++; $display("FAIL inc_%0d got %h want %h", i, out_o, 16'(i)); end
    end
    // Asynchronous reset mid-count, away from any clock edge.
    #2;
    rst_n = 0;
    #1;
    vec_cnt++;
    if (out_o !== 16'h0000) begin err_cnt++; $display("FAIL async_reset got %h want 0000", out_o); end
    idle();
    @(negedge clk_i);
    rst_n = 1;
    tick();
    vec_cnt++;
    if (out_o !== 16'h0000) begin err_cnt++; $display("FAIL post_reset_hold got %h want 0000", out_o); end
  endtask

  task automatic test_wrap();
    do_load(16'hFFFF);
    inc_i = 1; tick(); idle();
    vec_cnt++;
    if (out_o !== 16'h0000 || wrap_o !== 1'b1) begin
      err_cnt++; $display("FAIL wrap_step1 got out=%h wrap=%b want out=0000 wrap=1", out_o, wrap_o);
    end
    vec_cnt++;
    if (out2 !== 16'h0001 || wrap2 !== 1'b1) begin
      err_cnt++; $display("FAIL wrap_step2 got out=%h wrap=%b want out=0001 wrap=1", out2, wrap2);
    end
    tick();
    vec_cnt++;
    if (wrap_o !== 1'b0 || wrap2 !== 1'b0) begin
      err_cnt++; $display("FAIL wrap_pulse_end got %b%b want 00", wrap_o, wrap2);
    end
    // A non-wrapping increment must not pulse.
    inc_i = 1; tick(); idle();
    vec_cnt++;
    if (out_o !== 16'h0001 || wrap_o !== 1'b0) begin
      err_cnt++; $display("FAIL inc_nowrap got out=%h wrap=%b want out=0001 wrap=0", out_o, wrap_o);
    end
  endtask

  task automatic test_call_ret();
    do_load(16'h0010);
    call_i = 1; in_i = 16'h0200; tick(); idle();
    vec_cnt++;
    if (out_o !== 16'h0200 || depth_cnt_o !== 4'd1) begin
      err_cnt++; $display("FAIL call got out=%h depth=%0d want out=0200 depth=1", out_o, depth_cnt_o);
    end
    ret_i = 1; tick(); idle();
    vec_cnt++;
    if (out_o !== 16'h0011 || depth_cnt_o !== 4'd0 || empty_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL ret got out=%h depth=%0d empty=%b want out=0011 depth=0 empty=1",
               out_o, depth_cnt_o, empty_o);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_ret [8];
    logic [15:0] cur;
    do_load(16'h0100);
    cur = 16'h0100;
    for (int i = 0; i < 8; i++) begin
      exp_ret[i] = cur + 16'd1;
      cur = 16'h1000 + 16'(i * 16);
      call_i = 1; in_i = cur; tick(); idle();
    end
    vec_cnt++;
    if (out_o !== 16'h1070 || depth_cnt_o !== 4'd8 || full_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL fill got out=%h depth=%0d full=%b want out=1070 depth=8 full=1",
               out_o, depth_cnt_o, full_o);
    end
    call_i = 1; in_i = 16'h1234; tick(); idle();
    vec_cnt++;
    if (out_o !== 16'h1070 || err_ovf_o !== 1'b1 || depth_cnt_o !== 4'd8) begin
      err_cnt++;
      $display("FAIL ovf got out=%h ovf=%b depth=%0d want out=1070 ovf=1 depth=8",
               out_o, err_ovf_o, depth_cnt_o);
    end
    tick();
    vec_cnt++;
    if (err_ovf_o !== 1'b0) begin err_cnt++; $display("FAIL ovf_pulse_end got %b want 0", err_ovf_o); end
    for (int i = 7; i >= 0; i--) begin
      ret_i = 1; tick(); idle();
      vec_cnt++;
      if (out_o !== exp_ret[i] || depth_cnt_o !== 4'(i)) begin
        err_cnt++;
        $display("FAIL unwind_%0d got out=%h depth=%0d want out=%h depth=%0d",
                 i, out_o, depth_cnt_o, exp_ret[i], i);
      end
    end
    ret_i = 1; tick(); idle();
    vec_cnt++;
    if (out_o !== 16'h0101 || err_unf_o !== 1'b1 || empty_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL unf got out=%h unf=%b empty=%b want out=0101 unf=1 empty=1",
               out_o, err_unf_o, empty_o);
    end
    tick();
    vec_cnt++;
    if (err_unf_o !== 1'b0) begin err_cnt++; $display("FAIL unf_pulse_end got %b want 0", err_unf_o); end
  endtask

  task automatic test_priority();
    do_load(16'h0050);
    call_i = 1; in_i = 16'h0300; tick(); idle();
    clr_i = 1; call_i = 1; inc_i = 1; in_i = 16'h0400; tick(); idle();
    vec_cnt++;
    if (out_o !== 16'h0000 || depth_cnt_o !== 4'd1 || err_ovf_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL clr_wins got out=%h depth=%0d ovf=%b want out=0000 depth=1 ovf=0",
               out_o, depth_cnt_o, err_ovf_o);
    end
    load_i = 1; inc_i = 1; in_i = 16'h0100; tick(); idle();
    vec_cnt++;
    if (out_o !== 16'h0100) begin err_cnt++; $display("FAIL load_wins got %h want 0100", out_o); end
    ret_i = 1; load_i = 1; in_i = 16'h0777; tick(); idle();
    vec_cnt++;
    if (out_o !== 16'h0051 || depth_cnt_o !== 4'd0) begin
      err_cnt++;
      $display("FAIL ret_wins got out=%h depth=%0d want out=0051 depth=0", out_o, depth_cnt_o);
    end
  endtask

  task automatic test_call_wrap();
    do_load(16'hFFFF);
    call_i = 1; in_i = 16'h0005; tick(); idle();
    vec_cnt++;
    if (out_o !== 16'h0005 || wrap_o !== 1'b1 || depth_cnt_o !== 4'd1) begin
      err_cnt++;
      $display("FAIL call_wrap got out=%h wrap=%b depth=%0d want out=0005 wrap=1 depth=1",
               out_o, wrap_o, depth_cnt_o);
    end
    ret_i = 1; tick(); idle();
    vec_cnt++;
    if (out_o !== 16'h0000 || wrap_o !== 1'b0 || depth_cnt_o !== 4'd0) begin
      err_cnt++;
      $display("FAIL call_wrap_ret got out=%h wrap=%b depth=%0d want out=0000 wrap=0 depth=0",
               out_o, wrap_o, depth_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    do_load(16'h0020);
    call_i = 1; in_i = 16'h0040; tick(); idle();
    vec_cnt++;
    if (out_o !== 16'h0040) begin err_cnt++; $display("FAIL b2b_call1 got %h want 0040", out_o); end
    ret_i = 1; tick(); idle();
    vec_cnt++;
    if (out_o !== 16'h0021) begin err_cnt++; $display("FAIL b2b_ret1 got %h want 0021", out_o); end
    call_i = 1; in_i = 16'h0060; tick(); idle();
    vec_cnt++;
    if (out_o !== 16'h0060) begin err_cnt++; $display("FAIL b2b_call2 got %h want 0060", out_o); end
    ret_i = 1; tick(); idle();
    vec_cnt++;
    if (out_o !== 16'h0022 || empty_o !== 1'b1) begin
      err_cnt++; $display("FAIL b2b_ret2 got out=%h empty=%b want out=0022 empty=1", out_o, empty_o);
    end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_wrap();
    test_call_ret();
    test_overflow();
    test_priority();
    test_call_wrap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
